// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: control sequencer for the Simple CPU v1.
//
// It steps each instruction through fetch, decode and execute. It drives the
// memory request handshake, the address-source select (pc or acc), the
// register load strobes and the ALU op code. A wait counter bounds how long
// a memory request may stay unacknowledged before the sequencer locks into ERR.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high; forces every output to 0
//   run      in   permits a new instruction fetch
//   ir[7:0]  in   instruction register; ir[7:5] opcode, ir[4:0] immediate
//   zero     in   acc == 0 flag from the datapath
//   mem_ack  in   memory completes the current request this cycle
//   muxa     out  address select: 1 = pc, 0 = acc
//   mem_req  out  memory read request
//   ir_ld    out  load ir from memory data
//   pc_inc   out  pc <= pc + 1
//   pc_ld    out  pc <= acc
//   acc_ld   out  load acc
//   acc_src  out  acc source: 0 = ALU result, 1 = memory data
//   alu_op   out  00 pass, 01 add imm, 10 sub imm, 11 and imm
//   halted   out  HLT executed
//   err      out  memory timeout occurred
module cpu_ctrl_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] ir,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       muxa,
  output logic       mem_req,
  output logic       ir_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       acc_ld,
  output logic       acc_src,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       err
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    opcode;
  logic          fetch_pend;
  logic          unused_imm;

  assign opcode = ir[7:5];

  // The immediate field feeds the datapath ALU directly. The sequencer does
  // not use it.
  assign unused_imm = ^ir[4:0];

  // The wait counter is cleared on entry to FETCH. A nonzero count in FETCH
  // therefore means a request went unacknowledged in an earlier cycle. That
  // request must persist even if run has since dropped.
  assign fetch_pend = (cnt_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    muxa       = 1'b0;
    mem_req    = 1'b0;
    ir_ld      = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    acc_ld     = 1'b0;
    acc_src    = 1'b0;
    alu_op     = 2'b00;
    halted     = 1'b0;
    err        = 1'b0;

    // While rst is high every output stays 0. This drops any request in flight.
    if (!rst) begin
      case (state_reg)
        FETCH: begin
          muxa = 1'b1;
          if (run || fetch_pend) begin
            mem_req = 1'b1;
            if (mem_ack) begin
              ir_ld      = 1'b1;
              pc_inc     = 1'b1;
              state_next = DECODE;
            end else if (cnt_reg == TMO) begin
              state_next = ERR;
            end
          end
        end
        DECODE: begin
          case (opcode)
            3'b001:  state_next = MEM;
            3'b111:  state_next = HALT;
            default: state_next = EXEC;
          endcase
        end
        EXEC: begin
          case (opcode)
            3'b010: begin acc_ld = 1'b1; alu_op = 2'b01; end
            3'b011: pc_ld = 1'b1;
            3'b100: pc_ld = zero;
            3'b101: begin acc_ld = 1'b1; alu_op = 2'b10; end
            3'b110: begin acc_ld = 1'b1; alu_op = 2'b11; end
            default: ;
          endcase
          state_next = FETCH;
        end
        MEM: begin
          // LDA: acc addresses memory, and the read data loads acc.
          mem_req = 1'b1;
          if (mem_ack) begin
            acc_ld     = 1'b1;
            acc_src    = 1'b1;
            state_next = FETCH;
          end else if (cnt_reg == TMO) begin
            state_next = ERR;
          end
        end
        HALT:    halted = 1'b1;
        ERR:     err    = 1'b1;
        default: state_next = FETCH;
      endcase
    end
  end

  // A fresh wait budget starts for each new request phase and after every
  // completed transfer. The counter saturates at TMO, so it cannot wrap back
  // below the timeout while a request is stuck.
  always_comb begin
    cnt_next = cnt_reg;
    if (mem_ack ||
        ((state_next != state_reg) && ((state_next == FETCH) || (state_next == MEM)))) begin
      cnt_next = '0;
    end else if (mem_req && (cnt_reg != TMO)) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Testbench for cpu_ctrl_fsm. It runs directed instruction scenarios and then
// randomized traffic. Every cycle is compared against a behavioural model of
// the instruction flow.
module tb_cpu_ctrl_fsm;

  localparam int TIMEOUT = 15;

  // Phases of the reference instruction flow.
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_HALT = 4, P_ERR = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1, run = 1'b0, zero = 1'b0, mem_ack = 1'b0;
  logic [7:0] ir = 8'h00;
  logic       muxa, mem_req, ir_ld, pc_inc, pc_ld, acc_ld, acc_src, halted, err;
  logic [1:0] alu_op;

  cpu_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CW(4)) dut (
    .clk(clk), .rst(rst), .run(run), .ir(ir), .zero(zero), .mem_ack(mem_ack),
    .muxa(muxa), .mem_req(mem_req), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .acc_ld(acc_ld), .acc_src(acc_src), .alu_op(alu_op), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stimulus for the next cycle.
  bit         rst_i = 1'b1, run_i = 1'b0, ack_i = 1'b0, zero_i = 1'b0;
  logic [7:0] mdata = 8'h00;

  // Reference model state.
  int ph      = P_FETCH;
  int waited  = 0;   // unacknowledged request cycles so far in this phase
  bit pending = 0;   // a fetch request is outstanding

  // Output vector: {muxa, mem_req, ir_ld, pc_inc, pc_ld, acc_ld, acc_src, alu_op, halted, err}
  logic [10:0] last_out, last_exp;

  function automatic logic [10:0] model_out();
    logic       m_muxa = 0, m_req = 0, m_irld = 0, m_pcinc = 0, m_pcld = 0;
    logic       m_accld = 0, m_accsrc = 0, m_halt = 0, m_err = 0;
    logic [1:0] m_alu = 0;
    if (!rst_i) begin
      if (ph == P_FETCH) begin
        m_muxa = 1;
        m_req  = run_i || pending;
        if (m_req && ack_i) begin m_irld = 1; m_pcinc = 1; end
      end else if (ph == P_EXEC) begin
        if (ir[7:5] == 3'd2) begin m_accld = 1; m_alu = 2'd1; end
        if (ir[7:5] == 3'd3) m_pcld = 1;
        if (ir[7:5] == 3'd4) m_pcld = zero_i;
        if (ir[7:5] == 3'd5) begin m_accld = 1; m_alu = 2'd2; end
        if (ir[7:5] == 3'd6) begin m_accld = 1; m_alu = 2'd3; end
      end else if (ph == P_MEM) begin
        m_req = 1;
        if (ack_i) begin m_accld = 1; m_accsrc = 1; end
      end else if (ph == P_HALT) begin
        m_halt = 1;
      end else if (ph == P_ERR) begin
        m_err = 1;
      end
    end
    return {m_muxa, m_req, m_irld, m_pcinc, m_pcld, m_accld, m_accsrc, m_alu, m_halt, m_err};
  endfunction

  task automatic model_update(input logic [10:0] e);
    if (rst_i) begin
      ph = P_FETCH; waited = 0; pending = 0;
    end else if (ph == P_FETCH || ph == P_MEM) begin
      if (e[9]) begin
        if (ack_i) begin
          ph = (ph == P_FETCH) ? P_DECODE : P_FETCH;
          waited = 0; pending = 0;
        end else if (waited == TIMEOUT) begin
          ph = P_ERR;
        end else begin
          waited++;
          pending = (ph == P_FETCH);
        end
      end
    end else if (ph == P_DECODE) begin
      if (ir[7:5] == 3'd1) begin ph = P_MEM; waited = 0; end
      else if (ir[7:5] == 3'd7) ph = P_HALT;
      else ph = P_EXEC;
    end else if (ph == P_EXEC) begin
      ph = P_FETCH; waited = 0; pending = 0;
    end
    // The ir register loads memory data when ir_ld fires.
    if (e[8]) ir = mdata;
  endtask

  task automatic step();
    @(negedge clk);
    rst = rst_i; run = run_i; mem_ack = ack_i; zero = zero_i;
    #1;
    last_out = {muxa, mem_req, ir_ld, pc_inc, pc_ld, acc_ld, acc_src, alu_op, halted, err};
    last_exp = model_out();
    check("cycle", 16'(last_out), 16'(last_exp));
    @(posedge clk);
    #1;
    model_update(last_exp);
  endtask

  task automatic do_reset();
    rst_i = 1; step(); rst_i = 0;
  endtask

  // Hold a request unacknowledged and return the number of request cycles
  // seen before err rises. The wait is bounded.
  task automatic count_to_timeout(input string tag);
    int req_cycles = 0;
    run_i = 1; ack_i = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) check({tag, "_first_muxa"}, 16'(last_out[10]), 16'd1);
      if (last_out[9]) req_cycles++;
      if (last_out[0]) break;
    end
    check({tag, "_req_cycles"}, 16'(req_cycles), 16'(TIMEOUT + 1));
    check({tag, "_err"}, 16'(last_out[0]), 16'd1);
    check({tag, "_req_off"}, 16'(last_out[9]), 16'd0);
  endtask

  initial begin
    int stall = 0;

    // Reset state.
    do_reset();
    check("reset_outs", 16'(last_out), 16'h000);

    // ADDI imm=1, then an LDA held off for 3 cycles.
    run_i = 1; ack_i = 1; mdata = 8'h41;
    step(); check("addi_fetch", 16'(last_out), 16'h780);
    mdata = 8'h20;
    step(); check("addi_decode", 16'(last_out), 16'h000);
    step(); check("addi_exec", 16'(last_out), 16'h024);
    step(); check("lda_fetch", 16'(last_out), 16'h780);
    step();
    ack_i = 0;
    for (int i = 0; i < 3; i++) begin
      step(); check("lda_wait", 16'(last_out), 16'h200);
    end
    ack_i = 1;
    step(); check("lda_ack", 16'(last_out), 16'h230);

    // JZ with zero set, then with zero clear.
    mdata = 8'h80; zero_i = 1;
    step(); step(); step(); check("jz_taken", 16'(last_out), 16'h040);
    zero_i = 0;
    step(); step(); step(); check("jz_not_taken", 16'(last_out), 16'h000);

    // Fetch timeout, then an ack landing exactly on the last permitted cycle.
    count_to_timeout("tmo");
    do_reset();
    mdata = 8'h00; run_i = 1; ack_i = 0;
    for (int i = 0; i < TIMEOUT; i++) step();
    ack_i = 1;
    step(); check("tmo_late_ack", 16'(last_out), 16'h780);
    ack_i = 0;
    step(); check("tmo_no_err", 16'(last_out), 16'h000);
    step();

    // HLT: run and mem_ack are ignored until reset.
    do_reset();
    run_i = 1; ack_i = 1; mdata = 8'hE0;
    step(); step(); step(); check("hlt_c2", 16'(last_out), 16'h002);
    for (int i = 0; i < 10; i++) begin
      run_i = 1'($urandom); ack_i = 1'($urandom);
      step(); check("hlt_ignore", 16'(last_out), 16'h002);
    end
    do_reset();
    check("hlt_rst", 16'(last_out), 16'h000);
    run_i = 1; ack_i = 0;
    step(); check("hlt_resume", 16'(last_out), 16'h600);

    // Reset during an LDA wait, then a full timeout budget after release.
    do_reset();
    run_i = 1; ack_i = 1; mdata = 8'h20;
    step(); step();
    ack_i = 0;
    step(); step(); step();
    rst_i = 1; step(); rst_i = 0;
    check("mem_rst", 16'(last_out), 16'h000);
    count_to_timeout("restart");
    do_reset();

    // Randomized traffic with occasional long stalls and resets.
    for (int n = 0; n < 3000; n++) begin
      rst_i  = ($urandom_range(0, 99) == 0);
      run_i  = ($urandom_range(0, 3) != 0);
      zero_i = 1'($urandom);
      mdata  = 8'($urandom);
      if (stall == 0 && $urandom_range(0, 39) == 0) stall = $urandom_range(10, 20);
      if (stall > 0) begin
        ack_i = 0; stall--;
      end else begin
        ack_i = ($urandom_range(0, 2) != 0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
